// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that shares one UART transmitter
// among NUM_REQ byte sources and generates the transmitter's baud enable.
// Optional feature macro: UART_TX_GAP_EN inserts GAP_BITS idle bit periods
// after each frame before the next grant.
//
// state     | meaning
// IDLE      | arbitrate among req_valid, latch winner id and byte
// ISSUE     | one-cycle write strobe to transmitter and ack to winner
// WAIT_BUSY | wait up to 3 cycles for transmitter busy; else drop frame
// WAIT_DONE | frame on the line, wait for busy to fall
// GAP       | (UART_TX_GAP_EN only) count GAP_BITS baud pulses
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_BITS     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_wr_en,
  output logic [7:0]                 tx_din,
  output logic                       tx_clk_en,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [15:0]                frame_cnt
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(CLKS_PER_BIT);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_sched: NUM_REQ must be 2..8");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_sched: CLKS_PER_BIT must be >= 2");
  end
  if (GAP_BITS < 1) begin : g_bad_gap_bits
    $error("uart_tx_sched: GAP_BITS must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
`ifdef UART_TX_GAP_EN
    , GAP
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_cnt;
  logic [GW-1:0] grant_q;
  logic [7:0]    din_q;
  logic [15:0]   frame_q;
  logic [1:0]    wait_q;
  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [7:0]    win_data;
  logic [GW-1:0] idx;

`ifdef UART_TX_GAP_EN
  localparam int GCW = $clog2(GAP_BITS + 1);
  logic [GCW-1:0] gap_q;
`endif

  // Free-running baud counter; the enable fires on the terminal count.
  always_ff @(posedge clk) begin
    if (reset)
      baud_cnt <= '0;
    else if (baud_cnt == BW'(CLKS_PER_BIT - 1))
      baud_cnt <= '0;
    else
      baud_cnt <= baud_cnt + 1'b1;
  end

  assign tx_clk_en = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  // Round-robin search starting one past the last grant, wrapping upward.
  always_comb begin
    win_found = 1'b0;
    win_idx   = grant_q;
    idx       = grant_q;
    win_data  = 8'h00;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(grant_q) + i) % NUM_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (GW'(j) == win_idx)
        win_data = req_data[8*j +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; write strobe and ack exist only in ISSUE.
  always_comb begin
    state_d   = state_q;
    tx_wr_en  = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (win_found)
          state_d = ISSUE;
      end
      ISSUE: begin
        tx_wr_en           = 1'b1;
        req_ready[grant_q] = 1'b1;
        state_d            = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)
          state_d = WAIT_DONE;
        else if (wait_q == 2'd0)
          state_d = IDLE;
      end
      WAIT_DONE: begin
        if (!tx_busy)
`ifdef UART_TX_GAP_EN
          state_d = GAP;
`else
          state_d = IDLE;
`endif
      end
`ifdef UART_TX_GAP_EN
      GAP: begin
        if (tx_clk_en && gap_q == GCW'(1))
          state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Grant/byte capture, frame counter, busy timeout and gap down-counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= GW'(NUM_REQ - 1);
      din_q   <= 8'h00;
      frame_q <= 16'h0000;
      wait_q  <= 2'd0;
`ifdef UART_TX_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_q <= win_idx;
            din_q   <= win_data;
          end
        end
        ISSUE: begin
          frame_q <= frame_q + 16'd1;
          wait_q  <= 2'd2;
        end
        WAIT_BUSY: begin
          if (wait_q != 2'd0)
            wait_q <= wait_q - 1'b1;
        end
`ifdef UART_TX_GAP_EN
        WAIT_DONE: begin
          if (!tx_busy)
            gap_q <= GCW'(GAP_BITS);
        end
        GAP: begin
          if (tx_clk_en)
            gap_q <= gap_q - 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign grant_id  = grant_q;
  assign tx_din    = din_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched with a small behavioural transmitter.
// Honours UART_TX_GAP_EN when it is defined for the build.
module tb_uart_tx_sched;
  localparam int NUM_REQ      = 4;
  localparam int CLKS_PER_BIT = 4;
  localparam int GAP_BITS     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_wr_en;
  logic [7:0]  tx_din;
  logic        tx_clk_en;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic       tx_ignore;
  logic [9:0] sh;
  logic [3:0] bit_cnt;
  logic [9:0] rx_bits;
  logic       tx_line;
  int         ready1_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .NUM_REQ      (NUM_REQ),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .GAP_BITS     (GAP_BITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_wr_en  (tx_wr_en),
    .tx_din    (tx_din),
    .tx_clk_en (tx_clk_en),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .frame_cnt (frame_cnt)
  );

  assign tx_line = tx_busy ? sh[0] : 1'b1;

  // Transmitter: start bit, 8 data bits LSB first, stop bit, one per clk_en.
  always @(posedge clk) begin
    if (reset) begin
      tx_busy <= 1'b0;
      sh      <= '1;
      bit_cnt <= 4'd0;
      rx_bits <= '0;
    end else if (tx_wr_en && !tx_busy && !tx_ignore) begin
      sh      <= {1'b1, tx_din, 1'b0};
      bit_cnt <= 4'd0;
      tx_busy <= 1'b1;
      rx_bits <= '0;
    end else if (tx_busy && tx_clk_en) begin
      rx_bits <= {tx_line, rx_bits[9:1]};
      sh      <= {1'b1, sh[9:1]};
      bit_cnt <= bit_cnt + 4'd1;
      if (bit_cnt == 4'd9)
        tx_busy <= 1'b0;
    end
  end

  // Count acknowledgements to requester 1.
  always @(negedge clk) begin
    if (req_ready[1] === 1'b1)
      ready1_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_wr(output int cycles, output int pulses);
    cycles = 0;
    pulses = 0;
    while (tx_wr_en !== 1'b1 && cycles < 400) begin
      if (tx_clk_en === 1'b1)
        pulses++;
      tick();
      cycles++;
    end
    check("wr_en_seen", {31'd0, tx_wr_en}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("busy_rise", {31'd0, tx_busy}, 32'd1);
    n = 0;
    while (tx_busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check("busy_fall", {31'd0, tx_busy}, 32'd0);
  endtask

  // Directed sequence.
  initial begin
    int cy, pu, r1, exp_id;
    logic [3:0] exp_rdy;

    reset     = 1'b1;
    req_valid = 4'h0;
    req_data  = 32'h0;
    tx_ignore = 1'b0;
    repeat (3) tick();

    check("rst_ready", req_ready, 4'h0);
    check("rst_wr_en", tx_wr_en, 1'b0);
    check("rst_din", tx_din, 8'h00);
    check("rst_clk_en", tx_clk_en, 1'b0);
    check("rst_grant", grant_id, 2'd3);
    check("rst_frame", frame_cnt, 16'd0);

    // Baud enable: pulses on cycles 4, 8, 12 after release.
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("clk_en_c%0d", c), tx_clk_en, (c % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("idle_wr_c%0d", c), tx_wr_en, 1'b0);
      tick();
    end
    check("idle_grant", grant_id, 2'd3);
    check("idle_frame", frame_cnt, 16'd0);

    // Single requester 2 with 0xA5.
    req_data  = 32'h00A5_0000;
    req_valid = 4'b0100;
    wait_wr(cy, pu);
    check("t2_din", tx_din, 8'hA5);
    check("t2_ready", req_ready, 4'b0100);
    check("t2_grant", grant_id, 2'd2);
    req_valid = 4'b0000;
    tick();
    check("t2_frame", frame_cnt, 16'd1);
    check("t2_wr_low", tx_wr_en, 1'b0);
    check("t2_ready_low", req_ready, 4'b0000);
    wait_done();
    check("t2_start_bit", rx_bits[0], 1'b0);
    check("t2_serial_byte", rx_bits[8:1], 8'hA5);
    check("t2_stop_bit", rx_bits[9], 1'b1);
    check("t2_din_hold", tx_din, 8'hA5);

    // All four valid: order 0,1,2,3,0; each write only after busy fell.
    do_reset();
    req_data  = 32'h1312_1110;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_wr(cy, pu);
      if (k > 0) begin
`ifdef UART_TX_GAP_EN
        check($sformatf("t5_gap_pulses_%0d", k), pu, GAP_BITS);
`else
        check($sformatf("t5_rearm_cycles_%0d", k), cy, 2);
`endif
      end
      exp_id  = k % 4;
      exp_rdy = 4'b0001 << exp_id;
      check($sformatf("t3_grant_%0d", k), grant_id, exp_id);
      check($sformatf("t3_din_%0d", k), tx_din, 8'h10 + 8'(exp_id));
      check($sformatf("t3_ready_%0d", k), req_ready, exp_rdy);
      check($sformatf("t3_busy_low_%0d", k), tx_busy, 1'b0);
      if (k == 4)
        req_valid = 4'h0;
      tick();
      check($sformatf("t3_frame_%0d", k), frame_cnt, k + 1);
      wait_done();
    end

    // Requester 1 drops during WAIT_DONE; requester 3 must win next.
    do_reset();
    req_data  = 32'h4433_2211;
    req_valid = 4'b1011;
    r1 = ready1_cnt;
    wait_wr(cy, pu);
    check("t4_grant0", grant_id, 2'd0);
    check("t4_ready0", req_ready, 4'b0001);
    tick();
    tick();
    tick();
    check("t4_in_wait_done", tx_busy, 1'b1);
    req_valid = 4'b1000;
    wait_done();
    wait_wr(cy, pu);
    check("t4_grant3", grant_id, 2'd3);
    check("t4_din3", tx_din, 8'h44);
    check("t4_ready3", req_ready, 4'b1000);
    req_valid = 4'b0000;
    check("t4_no_ready1", ready1_cnt - r1, 0);
    wait_done();

    // Transmitter never goes busy: frame dropped after 3 cycles, no retry stall.
    do_reset();
    tx_ignore = 1'b1;
    req_data  = 32'h0000_0077;
    req_valid = 4'b0001;
    wait_wr(cy, pu);
    check("to_grant", grant_id, 2'd0);
    tick();
    wait_wr(cy, pu);
    check("to_reissue_cycles", cy, 4);
    check("to_frame_kept", frame_cnt, 16'd1);
    req_valid = 4'b0000;
    tick();
    check("to_frame2", frame_cnt, 16'd2);
    tx_ignore = 1'b0;
    repeat (4) tick();

    // Reset in WAIT_DONE.
    do_reset();
    req_data  = 32'h1312_1110;
    req_valid = 4'hF;
    wait_wr(cy, pu);
    tick();
    tick();
    tick();
    check("t6_in_wait_done", tx_busy, 1'b1);
    reset = 1'b1;
    tick();
    check("t6_grant", grant_id, 2'd3);
    check("t6_frame", frame_cnt, 16'd0);
    check("t6_wr_en", tx_wr_en, 1'b0);
    check("t6_ready", req_ready, 4'h0);
    check("t6_clk_en", tx_clk_en, 1'b0);
    reset = 1'b0;
    wait_wr(cy, pu);
    check("t6_first_cycles", cy, 1);
    check("t6_first_grant", grant_id, 2'd0);
    check("t6_first_din", tx_din, 8'h10);
    req_valid = 4'h0;
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
